// File: rtl/median3x3_stream_if.sv
// Column-in / median-out stream bundle for median3x3_stream.
// The master side feeds columns and accepts medians; the slave side is the filter core.
interface median3x3_stream_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sol;
  logic [WIDTH-1:0] in_col_t;
  logic [WIDTH-1:0] in_col_m;
  logic [WIDTH-1:0] in_col_b;
  logic             out_valid;
  logic             out_ready;
  logic             out_sol;
  logic [WIDTH-1:0] out_median;

  modport master (
    output in_valid, in_sol, in_col_t, in_col_m, in_col_b, out_ready,
    input  in_ready, out_valid, out_sol, out_median
  );

  modport slave (
    input  in_valid, in_sol, in_col_t, in_col_m, in_col_b, out_ready,
    output in_ready, out_valid, out_sol, out_median
  );
endinterface

// File: rtl/median3x3_stream.sv
// Streaming 3x3 median: sort each incoming column, reduce the three-column window,
// then take the median of three; every stage stalls together on output backpressure.
module median3x3_stream #(
  parameter int WIDTH     = 8,
  parameter bit REPLICATE = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  median3x3_stream_if.slave bus
);

  typedef logic [WIDTH-1:0] pix_t;
  typedef struct packed {
    pix_t lo;
    pix_t mid;
    pix_t hi;
  } col_t;

  function automatic pix_t max2(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic pix_t min2(input pix_t a, input pix_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
    return max2(max2(a, b), c);
  endfunction

  function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
    return min2(min2(a, b), c);
  endfunction

  function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  // Three compare-exchange cells: (0,1), (1,2), (0,1).
  function automatic col_t sort3(input pix_t a, input pix_t b, input pix_t c);
    pix_t x0;
    pix_t x1;
    pix_t x2;
    pix_t tmp;
    col_t r;
    x0 = a;
    x1 = b;
    x2 = c;
    if (x0 > x1) begin tmp = x0; x0 = x1; x1 = tmp; end
    if (x1 > x2) begin tmp = x1; x1 = x2; x2 = tmp; end
    if (x0 > x1) begin tmp = x0; x0 = x1; x1 = tmp; end
    r.lo  = x0;
    r.mid = x1;
    r.hi  = x2;
    return r;
  endfunction

  logic       adv;
  logic       accept;
  logic [1:0] col_count;
  logic [1:0] count_next;
  logic       first_full;
  col_t       col_sorted;
  col_t       h0;
  col_t       h1;
  col_t       h2;
  logic       s1_valid;
  logic       s1_sol;
  pix_t       s2_lo_max;
  pix_t       s2_mid_med;
  pix_t       s2_hi_min;
  logic       s2_valid;
  logic       s2_sol;
  pix_t       out_median_q;
  logic       out_valid_q;
  logic       out_sol_q;

  assign adv            = !out_valid_q || bus.out_ready;
  assign accept         = bus.in_valid && adv;
  assign bus.in_ready   = adv;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_sol    = out_sol_q;
  assign bus.out_median = out_median_q;

  // first_full marks the accept that brings a line to three held columns,
  // which is where a non-replicating line emits its first output.
  always_comb begin
    col_sorted = sort3(bus.in_col_t, bus.in_col_m, bus.in_col_b);
    if (bus.in_sol) begin
      count_next = 2'd1;
    end else if (col_count == 2'd3) begin
      count_next = 2'd3;
    end else begin
      count_next = col_count + 2'd1;
    end
    first_full = (count_next == 2'd3) && (col_count != 2'd3);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h0        <= '0;
      h1        <= '0;
      h2        <= '0;
      col_count <= 2'd0;
      s1_valid  <= 1'b0;
      s1_sol    <= 1'b0;
    end else if (adv) begin
      s1_valid <= accept && (REPLICATE || (count_next == 2'd3));
      s1_sol   <= accept && (REPLICATE ? bus.in_sol : first_full);
      if (accept) begin
        col_count <= count_next;
        if (REPLICATE && bus.in_sol) begin
          h2 <= col_sorted;
          h1 <= col_sorted;
          h0 <= col_sorted;
        end else begin
          h2 <= h1;
          h1 <= h0;
          h0 <= col_sorted;
        end
      end
    end
  end

  // With every column sorted, the window median lies between the largest low,
  // the median of the mids and the smallest high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_lo_max  <= '0;
      s2_mid_med <= '0;
      s2_hi_min  <= '0;
      s2_valid   <= 1'b0;
      s2_sol     <= 1'b0;
    end else if (adv) begin
      s2_lo_max  <= max3(h2.lo, h1.lo, h0.lo);
      s2_mid_med <= med3(h2.mid, h1.mid, h0.mid);
      s2_hi_min  <= min3(h2.hi, h1.hi, h0.hi);
      s2_valid   <= s1_valid;
      s2_sol     <= s1_sol;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_median_q <= '0;
      out_valid_q  <= 1'b0;
      out_sol_q    <= 1'b0;
    end else if (adv) begin
      out_median_q <= med3(s2_lo_max, s2_mid_med, s2_hi_min);
      out_valid_q  <= s2_valid;
      out_sol_q    <= s2_sol;
    end
  end

endmodule

// File: tb/tb_median3x3_stream.sv
// Self-checking bench for median3x3_stream: fixed vector table, handshake sequences
// and randomized streams scored against a 9-pixel sort-based median model.
module tb_median3x3_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  median3x3_stream_if #(.WIDTH(8))  if0 ();
  median3x3_stream_if #(.WIDTH(8))  if1 ();
  median3x3_stream_if #(.WIDTH(12)) if2 ();

  median3x3_stream #(.WIDTH(8),  .REPLICATE(1'b1)) dut_rep (.clk(clk), .rst_n(rst_n), .bus(if0));
  median3x3_stream #(.WIDTH(8),  .REPLICATE(1'b0)) dut_sup (.clk(clk), .rst_n(rst_n), .bus(if1));
  median3x3_stream #(.WIDTH(12), .REPLICATE(1'b1)) dut_w12 (.clk(clk), .rst_n(rst_n), .bus(if2));

  // Instance 0: 8-bit replicate, 1: 8-bit suppress, 2: 12-bit replicate.
  logic        drv_valid [3];
  logic        drv_sol   [3];
  logic        drv_ordy  [3];
  logic [11:0] drv_t     [3];
  logic [11:0] drv_m     [3];
  logic [11:0] drv_b     [3];
  logic        mon_valid [3];
  logic        mon_ready [3];
  logic        mon_sol   [3];
  logic [11:0] mon_med   [3];

  assign if0.in_valid  = drv_valid[0];
  assign if0.in_sol    = drv_sol[0];
  assign if0.in_col_t  = drv_t[0][7:0];
  assign if0.in_col_m  = drv_m[0][7:0];
  assign if0.in_col_b  = drv_b[0][7:0];
  assign if0.out_ready = drv_ordy[0];
  assign mon_valid[0]  = if0.out_valid;
  assign mon_ready[0]  = if0.in_ready;
  assign mon_sol[0]    = if0.out_sol;
  assign mon_med[0]    = {4'd0, if0.out_median};

  assign if1.in_valid  = drv_valid[1];
  assign if1.in_sol    = drv_sol[1];
  assign if1.in_col_t  = drv_t[1][7:0];
  assign if1.in_col_m  = drv_m[1][7:0];
  assign if1.in_col_b  = drv_b[1][7:0];
  assign if1.out_ready = drv_ordy[1];
  assign mon_valid[1]  = if1.out_valid;
  assign mon_ready[1]  = if1.in_ready;
  assign mon_sol[1]    = if1.out_sol;
  assign mon_med[1]    = {4'd0, if1.out_median};

  assign if2.in_valid  = drv_valid[2];
  assign if2.in_sol    = drv_sol[2];
  assign if2.in_col_t  = drv_t[2];
  assign if2.in_col_m  = drv_m[2];
  assign if2.in_col_b  = drv_b[2];
  assign if2.out_ready = drv_ordy[2];
  assign mon_valid[2]  = if2.out_valid;
  assign mon_ready[2]  = if2.in_ready;
  assign mon_sol[2]    = if2.out_sol;
  assign mon_med[2]    = if2.out_median;

  typedef struct packed {
    int          inst;
    bit          valid;
    bit          sol;
    logic [11:0] t;
    logic [11:0] m;
    logic [11:0] b;
    bit          exp_valid;
    bit          exp_sol;
    logic [11:0] exp_med;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  int          checks = 0;
  int          errors = 0;
  int          out_count;
  logic [12:0] exp_q [$];
  logic [11:0] mh [3][3];
  int          mcount;
  bit          memitted;
  bit          prev_stall;
  logic [11:0] prev_med;
  logic        prev_sol;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input int inst, input bit valid, input bit sol,
                              input int t, input int m, input int b,
                              input bit ev, input bit es, input int em);
    vec_t v;
    v.inst = inst;
    v.valid = valid;
    v.sol = sol;
    v.t = 12'(t);
    v.m = 12'(m);
    v.b = 12'(b);
    v.exp_valid = ev;
    v.exp_sol = es;
    v.exp_med = 12'(em);
    return v;
  endfunction

  // Reference: plain sort of all nine window pixels, take the fifth.
  function automatic logic [11:0] median9();
    int v [9];
    int tmp;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++)
        v[c*3 + r] = int'(mh[c][r]);
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin
          tmp = v[j]; v[j] = v[j+1]; v[j+1] = tmp;
        end
    return 12'(v[4]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++)
        mh[c][r] = 12'd0;
    mcount = 0;
    memitted = 1'b0;
    exp_q.delete();
    prev_stall = 1'b0;
    prev_med = 12'd0;
    prev_sol = 1'b0;
    out_count = 0;
  endtask

  task automatic model_accept(input int sel, input bit sol,
                              input logic [11:0] t, input logic [11:0] m, input logic [11:0] b);
    bit rep;
    bit first;
    rep = (sel != 1);
    if (sol && rep) begin
      for (int c = 0; c < 3; c++) begin
        mh[c][0] = t; mh[c][1] = m; mh[c][2] = b;
      end
    end else begin
      for (int r = 0; r < 3; r++) begin
        mh[2][r] = mh[1][r];
        mh[1][r] = mh[0][r];
      end
      mh[0][0] = t; mh[0][1] = m; mh[0][2] = b;
    end
    if (sol) begin
      mcount = 1;
      memitted = 1'b0;
    end else if (mcount < 3) begin
      mcount++;
    end
    if (rep || mcount == 3) begin
      first = rep ? sol : !memitted;
      memitted = 1'b1;
      exp_q.push_back({first, median9()});
    end
  endtask

  task automatic apply_stimulus(input int sel, input bit valid, input bit sol,
                                input logic [11:0] t, input logic [11:0] m,
                                input logic [11:0] b, input bit ordy);
    for (int i = 0; i < 3; i++) begin
      drv_valid[i] = 1'b0;
      drv_sol[i] = 1'b0;
    end
    drv_valid[sel] = valid;
    drv_sol[sel] = sol;
    drv_t[sel] = t;
    drv_m[sel] = m;
    drv_b[sel] = b;
    drv_ordy[sel] = ordy;
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next one.
  task automatic step(input int sel, output bit acc);
    logic [12:0] e;
    acc = 1'b0;
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      check_output("in_ready", int'(mon_ready[sel]), int'(!mon_valid[sel] || drv_ordy[sel]));
      if (prev_stall) begin
        check_output("held_median", int'(mon_med[sel]), int'(prev_med));
        check_output("held_sol", int'(mon_sol[sel]), int'(prev_sol));
      end
      if (mon_valid[sel] && drv_ordy[sel]) begin
        out_count++;
        check_output("out_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_output("median", int'(mon_med[sel]), int'(e[11:0]));
          check_output("out_sol", int'(mon_sol[sel]), int'(e[12]));
        end
      end
      acc = drv_valid[sel] && mon_ready[sel];
      if (acc) model_accept(sel, drv_sol[sel], drv_t[sel], drv_m[sel], drv_b[sel]);
      prev_stall = mon_valid[sel] && !drv_ordy[sel];
      prev_med = mon_med[sel];
      prev_sol = mon_sol[sel];
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv_valid[i] = 1'b0;
      drv_sol[i] = 1'b0;
      drv_ordy[i] = 1'b1;
      drv_t[i] = 12'd0;
      drv_m[i] = 12'd0;
      drv_b[i] = 12'd0;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic drain(input int sel, input string name);
    bit acc;
    apply_stimulus(sel, 1'b0, 1'b0, 12'd0, 12'd0, 12'd0, 1'b1);
    for (int i = 0; i < 12; i++) step(sel, acc);
    check_output(name, exp_q.size(), 0);
  endtask

  task automatic rand_run(input int sel, input int n, input bit first_sol);
    bit acc;
    logic [11:0] mask;
    mask = (sel == 2) ? 12'hFFF : 12'h0FF;
    do_reset();
    for (int i = 0; i < n; i++) begin
      apply_stimulus(sel, $urandom_range(0, 3) != 0,
                     (first_sol && i == 0) || ($urandom_range(0, 7) == 0),
                     12'($urandom) & mask, 12'($urandom) & mask, 12'($urandom) & mask,
                     $urandom_range(0, 3) != 0);
      step(sel, acc);
    end
    drain(sel, "rand_drain");
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end

  initial begin
    bit acc;
    int k;
    int cyc;
    vec_t r;
    logic [11:0] bp_col [6][3];

    vecs[0]  = mk(0, 1, 1,   9,   1,   5, 1, 1,   5);
    vecs[1]  = mk(0, 1, 1,   1,   2,   3, 1, 1,   2);
    vecs[2]  = mk(0, 1, 0,   4,   5,   6, 1, 0,   3);
    vecs[3]  = mk(0, 1, 0,   7,   8,   9, 1, 0,   5);
    vecs[4]  = mk(1, 1, 1,   1,   2,   3, 0, 0,   0);
    vecs[5]  = mk(1, 1, 0,   4,   5,   6, 0, 0,   0);
    vecs[6]  = mk(1, 1, 0,   7,   8,   9, 1, 1,   5);
    vecs[7]  = mk(1, 1, 1, 255, 255, 255, 0, 0,   0);
    vecs[8]  = mk(1, 1, 0, 255, 255, 255, 0, 0,   0);
    vecs[9]  = mk(1, 1, 0, 255, 255, 255, 1, 1, 255);
    vecs[10] = mk(1, 1, 1,   0,   0,   0, 0, 0,   0);
    vecs[11] = mk(1, 1, 0, 255, 255, 255, 0, 0,   0);
    vecs[12] = mk(1, 1, 0,   0, 255,   0, 1, 1,   0);
    vecs[13] = mk(1, 1, 0,   9,   9,   9, 1, 0,   9);
    vecs[14] = mk(0, 1, 0, 200,   3, 100, 1, 0,   7);
    vecs[15] = mk(0, 0, 0,  50,  60,  70, 0, 0,   0);

    do_reset();

    drv_ordy[0] = 1'b0;
    #1;
    check_output("reset_out_valid", int'(mon_valid[0]), 0);
    check_output("reset_out_sol", int'(mon_sol[0]), 0);
    check_output("reset_out_median", int'(mon_med[0]), 0);
    check_output("reset_in_ready", int'(mon_ready[0]), 1);
    @(negedge clk);
    drv_ordy[0] = 1'b1;

    // Fixed vectors: the output for vector i is visible three cycles after it is driven.
    for (int i = 0; i < NV + 3; i++) begin
      if (i >= 3) begin
        r = vecs[i-3];
        check_output($sformatf("vec%0d_valid", i-3), int'(mon_valid[r.inst]), int'(r.exp_valid));
        if (r.exp_valid) begin
          check_output($sformatf("vec%0d_median", i-3), int'(mon_med[r.inst]), int'(r.exp_med));
          check_output($sformatf("vec%0d_sol", i-3), int'(mon_sol[r.inst]), int'(r.exp_sol));
        end
      end
      if (i < NV) begin
        apply_stimulus(vecs[i].inst, vecs[i].valid, vecs[i].sol,
                       vecs[i].t, vecs[i].m, vecs[i].b, 1'b1);
      end else begin
        apply_stimulus(0, 1'b0, 1'b0, 12'd0, 12'd0, 12'd0, 1'b1);
      end
      @(negedge clk);
    end

    // Backpressure: six columns with a four-cycle output stall in the middle.
    do_reset();
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 3; j++)
        bp_col[i][j] = 12'($urandom_range(0, 255));
    k = 0;
    cyc = 0;
    while (k < 6 && cyc < 40) begin
      apply_stimulus(0, 1'b1, k == 0, bp_col[k][0], bp_col[k][1], bp_col[k][2],
                     !(cyc >= 3 && cyc < 7));
      step(0, acc);
      if (acc) k++;
      cyc++;
    end
    check_output("bp_accepted", k, 6);
    drain(0, "bp_drain");
    check_output("bp_out_count", out_count, 6);

    // Mid-stream reset on the suppressing instance with two outputs in flight.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1, 1'b1, i == 0, 12'(10 * i + 3), 12'(10 * i + 1), 12'(10 * i + 7), 1'b1);
      step(1, acc);
    end
    rst_n = 1'b0;
    apply_stimulus(1, 1'b0, 1'b0, 12'd0, 12'd0, 12'd0, 1'b1);
    step(1, acc);
    rst_n = 1'b1;
    #1;
    check_output("rst_flush_valid", int'(mon_valid[1]), 0);
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1, 1'b1, 1'b0, 12'(40 + i), 12'(90 - i), 12'(7 * i), 1'b1);
      step(1, acc);
    end
    apply_stimulus(1, 1'b0, 1'b0, 12'd0, 12'd0, 12'd0, 1'b1);
    for (int i = 0; i < 4; i++) step(1, acc);
    check_output("rst_no_early_out", out_count, 0);
    apply_stimulus(1, 1'b1, 1'b0, 12'd200, 12'd17, 12'd66, 1'b1);
    step(1, acc);
    drain(1, "rst_drain");
    check_output("rst_out_count", out_count, 1);

    rand_run(2, 300, 1'b0);
    rand_run(1, 300, 1'b1);
    rand_run(0, 200, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
